// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// Round-robin arbiter/sequencer for a shared single-wire tristate net driven
// by NREQ notif1/bufif1-style gates. It produces the per-gate enable so that at
// most one driver is ever on. It also guarantees an all-off turnaround window
// of at least TURN_CYCLES cycles between two ownership periods, including a
// re-grant to the same owner.
//
// Parameters
//   NREQ        number of requesters / tristate drivers (2..16)
//   MAXHOLD     maximum consecutive drive cycles while another requester waits
//   TURN_CYCLES all-off cycles between two ownership periods (>= 1)
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   asynchronous, active-high reset (drops all enables at once)
//   req      in   [NREQ]  level request per driver, held while the bus is wanted
//   gnt      out  [NREQ]  registered one-hot (or zero) grant
//   drv_en   out  [NREQ]  tristate gate enables, identical to gnt
//   bus_z    out          high while no driver is enabled (net floating)
//   preempt  out          one-cycle pulse after a MAXHOLD forced release
//   owner    out  [clog2(NREQ)] index of the current owner, 0 while bus_z=1
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
  parameter int NREQ        = 4,
  parameter int MAXHOLD     = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         drv_en,
  output logic                    bus_z,
  output logic                    preempt,
  output logic [$clog2(NREQ)-1:0] owner
);

  localparam int OW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD + 1);
  localparam int TW = $clog2(TURN_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_MAX  = HW'(MAXHOLD);
  localparam logic [TW-1:0] TURN_INIT = TW'(TURN_CYCLES);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("tristate_bus_arbiter: NREQ must be in 2..16");
  end
  if (MAXHOLD < 1) begin : g_bad_maxhold
    $error("tristate_bus_arbiter: MAXHOLD must be >= 1");
  end
  if (TURN_CYCLES < 1) begin : g_bad_turn
    $error("tristate_bus_arbiter: TURN_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_TURN
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,   state_d;
  logic [NREQ-1:0] gnt_q,     gnt_d;
  logic [OW-1:0]   owner_q,   owner_d;
  logic [OW-1:0]   ptr_q,     ptr_d;
  logic [HW-1:0]   hold_q,    hold_d;
  logic [TW-1:0]   turn_q,    turn_d;
  logic            preempt_q, preempt_d;

  // Index arithmetic modulo NREQ; works for non-power-of-2 NREQ where the
  // natural OW-bit wrap would be wrong.
  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] base,
                                             input int            offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NREQ) sum = sum - NREQ;
    return OW'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set req bit scanning ptr, ptr+1, ... (mod NREQ).
  // ---------------------------------------------------------------------------
  logic            arb_found;
  logic [OW-1:0]   arb_winner;
  logic [NREQ-1:0] arb_onehot;
  logic [OW-1:0]   arb_ptr_nxt;

  always_comb begin
    arb_found  = 1'b0;
    arb_winner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!arb_found && req[wrap_add(ptr_q, i)]) begin
        arb_found  = 1'b1;
        arb_winner = wrap_add(ptr_q, i);
      end
    end
    arb_onehot  = NREQ'(1) << arb_winner;
    // The winner gets lowest priority in the next arbitration.
    arb_ptr_nxt = wrap_add(arb_winner, 1);
  end

  // Only the owner's bit is set in gnt_q during DRIVE, so masking it out
  // leaves exactly the competing requests.
  logic others_req;
  assign others_req = |(req & ~gnt_q);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic do_grant;
  logic do_release;

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    hold_d     = hold_q;
    turn_d     = turn_q;
    preempt_d  = 1'b0;
    do_grant   = 1'b0;
    do_release = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        do_grant = arb_found;
      end

      S_DRIVE: begin
        if (!req[owner_q]) begin
          // Owner let go; wins over a simultaneous MAXHOLD hit, so no preempt.
          do_release = 1'b1;
        end else if (hold_q == HOLD_MAX && others_req) begin
          do_release = 1'b1;
          preempt_d  = 1'b1;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HW'(1);
        end
      end

      S_TURN: begin
        turn_d = turn_q - TW'(1);
        // Arbitration happens only on the last turnaround edge so requests
        // that appear during TURN cannot shorten the all-off window.
        if (turn_q == TW'(1)) begin
          if (arb_found) begin
            do_grant = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        owner_d = '0;
      end
    endcase

    if (do_grant) begin
      state_d = S_DRIVE;
      gnt_d   = arb_onehot;
      owner_d = arb_winner;
      ptr_d   = arb_ptr_nxt;
      hold_d  = HW'(1);
    end

    if (do_release) begin
      state_d = S_TURN;
      gnt_d   = '0;
      owner_d = '0;
      hold_d  = '0;
      turn_d  = TURN_INIT;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q   <= S_IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      turn_q    <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      turn_q    <= turn_d;
      preempt_q <= preempt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all straight from registers, so the gate enables are glitch-free
  // and the async reset clears them without waiting for a clock.
  // ---------------------------------------------------------------------------
  assign gnt     = gnt_q;
  assign drv_en  = gnt_q;
  assign bus_z   = ~|gnt_q;
  assign preempt = preempt_q;
  assign owner   = owner_q;

  // ---------------------------------------------------------------------------
  // Bus-safety invariants
  // ---------------------------------------------------------------------------
  a_onehot_drv: assert property (@(posedge clk) disable iff (rst)
    $onehot0(drv_en));

  a_bus_z: assert property (@(posedge clk) disable iff (rst)
    bus_z == ~|drv_en);

  // A non-zero enable may only continue unchanged; any change of owner or a
  // re-grant has to pass through zero.
  a_no_direct_switch: assert property (@(posedge clk) disable iff (rst)
    (|drv_en && $past(|drv_en)) |-> drv_en == $past(drv_en));

  // Every new ownership period is preceded by TURN_CYCLES all-off cycles.
  for (genvar k = 1; k <= TURN_CYCLES; k++) begin : g_turn_gap
    a_turn_gap: assert property (@(posedge clk) disable iff (rst)
      $rose(|drv_en) |-> $past(drv_en, k) == '0);
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//
// Directed bench for tristate_bus_arbiter. Three instances cover the default
// configuration (NREQ=4, MAXHOLD=8, TURN_CYCLES=1), a two-cycle turnaround
// and a non-power-of-2 NREQ=3. Inputs change #1 after a rising edge and
// outputs are sampled at that same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default configuration
  logic [3:0] req_a, gnt_a, drv_a;
  logic       busz_a, pre_a;
  logic [1:0] own_a;

  // TURN_CYCLES = 2
  logic [3:0] req_b, gnt_b, drv_b;
  logic       busz_b, pre_b;
  logic [1:0] own_b;

  // NREQ = 3
  logic [2:0] req_c, gnt_c, drv_c;
  logic       busz_c, pre_c;
  logic [1:0] own_c;

  tristate_bus_arbiter #(.NREQ(4), .MAXHOLD(8), .TURN_CYCLES(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .drv_en(drv_a),
    .bus_z(busz_a), .preempt(pre_a), .owner(own_a)
  );

  tristate_bus_arbiter #(.NREQ(4), .MAXHOLD(8), .TURN_CYCLES(2)) u_dut_b (
    .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .drv_en(drv_b),
    .bus_z(busz_b), .preempt(pre_b), .owner(own_b)
  );

  tristate_bus_arbiter #(.NREQ(3), .MAXHOLD(8), .TURN_CYCLES(1)) u_dut_c (
    .clk(clk), .rst(rst), .req(req_c), .gnt(gnt_c), .drv_en(drv_c),
    .bus_z(busz_c), .preempt(pre_c), .owner(own_c)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across two edges, releases it #1 after an edge.
  task automatic do_reset();
    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_pre;
    int exp_drv;
    int phase;
    int slot;
    int bad;

    rst   = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;

    // ---------------- reset state and simple grant/release ----------------
    do_reset();
    check("rst_gnt",   32'(gnt_a),  32'h0);
    check("rst_drv",   32'(drv_a),  32'h0);
    check("rst_busz",  32'(busz_a), 32'h1);
    check("rst_pre",   32'(pre_a),  32'h0);
    check("rst_owner", 32'(own_a),  32'h0);

    req_a = 4'b0100;
    tick();
    check("t1_drv",   32'(drv_a),  32'b0100);
    check("t1_gnt",   32'(gnt_a),  32'b0100);
    check("t1_owner", 32'(own_a),  32'd2);
    check("t1_busz",  32'(busz_a), 32'h0);
    repeat (3) begin
      tick();
      check("t1_hold_drv", 32'(drv_a), 32'b0100);
    end
    req_a = 4'b0000;
    tick();
    check("t1_rel_drv",   32'(drv_a),  32'h0);
    check("t1_rel_busz",  32'(busz_a), 32'h1);
    check("t1_rel_owner", 32'(own_a),  32'h0);
    tick();
    check("t1_idle_drv", 32'(drv_a), 32'h0);

    // Pointer is now 3: with req 1001, driver 3 wins over driver 0.
    req_a = 4'b1001;
    tick();
    check("t1_rr_drv",   32'(drv_a), 32'b1000);
    check("t1_rr_owner", 32'(own_a), 32'd3);
    req_a = 4'b0000;
    repeat (2) tick();

    // ---------------- full rotation with MAXHOLD preemption ----------------
    do_reset();
    req_a = 4'b1111;
    n_pre = 0;
    for (int t = 1; t <= 45; t++) begin
      tick();
      phase   = (t - 1) % 9;
      slot    = ((t - 1) / 9) % 4;
      exp_drv = (phase == 8) ? 0 : (1 << slot);
      check("rot_drv", 32'(drv_a), 32'(exp_drv));
      check("rot_pre", 32'(pre_a), (phase == 8) ? 32'h1 : 32'h0);
      if (phase != 8) check("rot_owner", 32'(own_a), 32'(slot));
      if (t <= 36 && pre_a) n_pre++;
    end
    check("rot_pre_count", 32'(n_pre), 32'd4);

    // ---------------- sole requester keeps the bus ----------------
    do_reset();
    req_a = 4'b0010;
    n_pre = 0;
    for (int t = 1; t <= 40; t++) begin
      tick();
      check("solo_drv", 32'(drv_a), 32'b0010);
      if (pre_a) n_pre++;
    end
    check("solo_pre_count", 32'(n_pre), 32'd0);

    // Hold is saturated: a newcomer forces release on the next edge.
    req_a = 4'b1010;
    tick();
    check("late_pre_drv", 32'(drv_a), 32'h0);
    check("late_pre_pre", 32'(pre_a), 32'h1);
    tick();
    check("late_new_drv",   32'(drv_a), 32'b1000);
    check("late_new_owner", 32'(own_a), 32'd3);
    check("late_new_pre",   32'(pre_a), 32'h0);
    repeat (7) begin
      tick();
      check("hold3_drv", 32'(drv_a), 32'b1000);
    end
    // Owner drops exactly when hold reaches MAXHOLD: normal release.
    req_a = 4'b0010;
    tick();
    check("simul_drv", 32'(drv_a), 32'h0);
    check("simul_pre", 32'(pre_a), 32'h0);
    tick();
    check("simul_next_drv",   32'(drv_a), 32'b0010);
    check("simul_next_owner", 32'(own_a), 32'd1);
    req_a = 4'b0000;
    repeat (2) tick();

    // ---------------- two-cycle turnaround ----------------
    do_reset();
    req_b = 4'b0010;
    tick();
    check("t2_first_drv", 32'(drv_b), 32'b0010);
    req_b = 4'b1000;
    tick();
    check("t2_gap1_drv",  32'(drv_b),  32'h0);
    check("t2_gap1_busz", 32'(busz_b), 32'h1);
    tick();
    check("t2_gap2_drv",  32'(drv_b),  32'h0);
    tick();
    check("t2_next_drv",   32'(drv_b), 32'b1000);
    check("t2_next_owner", 32'(own_b), 32'd3);
    check("t2_next_pre",   32'(pre_b), 32'h0);
    req_b = 4'b0000;

    // ---------------- asynchronous reset mid-drive ----------------
    do_reset();
    req_a = 4'b1111;
    tick();
    check("arst_pre_drv", 32'(drv_a), 32'b0001);
    #3 rst = 1'b1;
    #1;
    check("arst_drv",   32'(drv_a),  32'h0);
    check("arst_gnt",   32'(gnt_a),  32'h0);
    check("arst_busz",  32'(busz_a), 32'h1);
    check("arst_owner", 32'(own_a),  32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("arst_ptr_drv", 32'(drv_a), 32'b0001);
    req_a = 4'b0000;

    // ---------------- NREQ=3 pointer wrap ----------------
    do_reset();
    req_c = 3'b101;
    for (int t = 1; t <= 36; t++) begin
      tick();
      phase   = (t - 1) % 9;
      slot    = ((t - 1) / 9) % 2;
      exp_drv = (phase == 8) ? 0 : ((slot == 0) ? 1 : 4);
      check("n3_drv", 32'(drv_c), 32'(exp_drv));
      if (phase != 8) check("n3_owner", 32'(own_c), (slot == 0) ? 32'd0 : 32'd2);
    end

    // Random request traffic: bus safety and owner/enable consistency.
    bad = 0;
    for (int t = 0; t < 1000; t++) begin
      req_c = 3'($urandom_range(0, 7));
      tick();
      if (!$onehot0(drv_c)) bad++;
      if (busz_c != ~|drv_c) bad++;
      if (|drv_c && drv_c != (3'b001 << own_c)) bad++;
      if (!(|drv_c) && own_c != 2'd0) bad++;
    end
    check("n3_rand_invariants", 32'(bad), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
